// File: rtl/pcie_msg_queue_ctrl.sv
// pcie_msg_queue_ctrl
//
// Per-queue bookkeeping for assembled PCIe messages. Each completion from the
// message receiver either bumps an error counter or is accepted into its queue.
// Acceptance advances that queue's write pointer, bumps its pending count and
// sets its sticky status bit. Software consumes messages via i_rd_done and
// clears status bits with a W1C level.
//
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   i_asm_valid/tag/len completion pulse, target queue, length in beats
//   i_rd_done/tag       software consumed one message from a queue
//   i_intr_clear        W1C level per queue status bit
//   i_intr_enable       interrupt mask per queue
//   i_wptr_sel          queue shown on o_q_wptr
//   o_intr_status       {zero, status[NUM_Q-1:0]}
//   o_q_wptr            {20'h0, pend[3:0], 2'b0, wptr[5:0]} of selected queue
//   o_err_cnt           {bad_tag, overflow, len_err, 8'h0}
//   o_msg_interrupt     registered OR of enabled status bits
module pcie_msg_queue_ctrl #(
    parameter int unsigned NUM_Q    = 15,
    parameter int unsigned QDEPTH   = 64,
    parameter int unsigned PTR_W    = 6,
    parameter int unsigned MAX_PEND = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_asm_valid,
    input  logic [3:0]  i_asm_tag,
    input  logic [11:0] i_asm_len,
    input  logic        i_rd_done,
    input  logic [3:0]  i_rd_tag,
    input  logic [31:0] i_intr_clear,
    input  logic [31:0] i_intr_enable,
    input  logic [3:0]  i_wptr_sel,
    output logic [31:0] o_intr_status,
    output logic [31:0] o_q_wptr,
    output logic [31:0] o_err_cnt,
    output logic        o_msg_interrupt
);

    localparam logic [3:0]  NumQTag   = 4'(NUM_Q);
    localparam logic [11:0] QDepthLen = 12'(QDEPTH);
    localparam logic [3:0]  MaxPend   = 4'(MAX_PEND);

    logic [PTR_W-1:0] wptr_q [NUM_Q];
    logic [PTR_W-1:0] wptr_d [NUM_Q];
    logic [3:0]       pend_q [NUM_Q];
    logic [3:0]       pend_d [NUM_Q];
    logic [NUM_Q-1:0] status_q, status_d;
    logic [7:0]       bad_tag_q, bad_tag_d;
    logic [7:0]       ovf_q, ovf_d;
    logic [7:0]       len_err_q, len_err_d;
    logic             intr_q, intr_d;

    logic             tag_ok, len_ok, rd_same, tag_full;
    logic             bad_tag_ev, len_err_ev, ovf_ev, accept;
    logic [NUM_Q-1:0] inc_vec, dec_vec;

    // Upper mask/clear bits have no queue behind them.
    logic unused_bits;
    assign unused_bits = ^{i_intr_clear[31:NUM_Q], i_intr_enable[31:NUM_Q]};

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Classify the incoming completion; exactly one outcome applies.
    always_comb begin
        tag_ok   = i_asm_tag < NumQTag;
        len_ok   = (i_asm_len != 12'd0) && (i_asm_len <= QDepthLen);
        rd_same  = i_rd_done && (i_rd_tag == i_asm_tag);
        tag_full = 1'b0;
        for (int q = 0; q < NUM_Q; q++) begin
            if (i_asm_tag == 4'(q)) begin
                tag_full = (pend_q[q] == MaxPend);
            end
        end
        bad_tag_ev = i_asm_valid && !tag_ok;
        len_err_ev = i_asm_valid && tag_ok && !len_ok;
        // A same-queue consume frees a slot this cycle, so a full queue still accepts.
        ovf_ev     = i_asm_valid && tag_ok && len_ok && tag_full && !rd_same;
        accept     = i_asm_valid && tag_ok && len_ok && !(tag_full && !rd_same);
    end

    // Per-queue next state.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            inc_vec[q] = accept && (i_asm_tag == 4'(q));
            dec_vec[q] = i_rd_done && (i_rd_tag == 4'(q)) && (pend_q[q] != 4'd0);
            wptr_d[q]  = inc_vec[q] ? wptr_q[q] + i_asm_len[PTR_W-1:0] : wptr_q[q];
            unique case ({inc_vec[q], dec_vec[q]})
                2'b10:   pend_d[q] = pend_q[q] + 4'd1;
                2'b01:   pend_d[q] = pend_q[q] - 4'd1;
                default: pend_d[q] = pend_q[q];
            endcase
        end
        // Set wins over clear on the same bit.
        status_d  = (status_q & ~i_intr_clear[NUM_Q-1:0]) | inc_vec;
        bad_tag_d = bad_tag_ev ? sat_inc(bad_tag_q) : bad_tag_q;
        len_err_d = len_err_ev ? sat_inc(len_err_q) : len_err_q;
        ovf_d     = ovf_ev     ? sat_inc(ovf_q)     : ovf_q;
        intr_d    = |(status_q & i_intr_enable[NUM_Q-1:0]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int q = 0; q < NUM_Q; q++) begin
                wptr_q[q] <= '0;
                pend_q[q] <= '0;
            end
            status_q  <= '0;
            bad_tag_q <= '0;
            ovf_q     <= '0;
            len_err_q <= '0;
            intr_q    <= 1'b0;
        end else begin
            for (int q = 0; q < NUM_Q; q++) begin
                wptr_q[q] <= wptr_d[q];
                pend_q[q] <= pend_d[q];
            end
            status_q  <= status_d;
            bad_tag_q <= bad_tag_d;
            ovf_q     <= ovf_d;
            len_err_q <= len_err_d;
            intr_q    <= intr_d;
        end
    end

    always_comb begin
        o_q_wptr = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            if (i_wptr_sel == 4'(q)) begin
                o_q_wptr[PTR_W-1:0] = wptr_q[q];
                o_q_wptr[11:8]      = pend_q[q];
            end
        end
    end

    assign o_intr_status   = {{(32 - NUM_Q){1'b0}}, status_q};
    assign o_err_cnt       = {bad_tag_q, ovf_q, len_err_q, 8'h00};
    assign o_msg_interrupt = intr_q;

endmodule

// File: doc/pcie_msg_queue_ctrl.md
# pcie_msg_queue_ctrl

Per-queue bookkeeping stage directly downstream of `pcie_msg_receiver`. It consumes each assembled-message completion (`assembled_valid` / `assembled_tag` plus message length) and maintains the state software needs to drain the SRAM queue regions. That state is a per-queue write pointer, a pending-message count, sticky W1C interrupt status, and saturating error counters. Its outputs feed the `Q_INTR_STATUS_0` / `Q_DATA_WPTR_0` SFRs and `o_msg_interrupt`.

## Interface
- `NUM_Q`, 15: number of queues. Tags 0..NUM_Q-1 are valid. Must be ≤15.
- `QDEPTH`, 64: beats per queue region. Power of two. Queue q region base = q*QDEPTH.
- `PTR_W`, 6: log2(QDEPTH), write-pointer width.
- `MAX_PEND`, 15: pending-count ceiling, 4-bit counter.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `i_asm_valid`  in  1  one-cycle pulse: an assembled message has been written to SRAM.
- `i_asm_tag`  in  4  MSG_TAG/queue of that message.
- `i_asm_len`  in  12  message length in 256-bit beats.
- `i_rd_done`  in  1  one-cycle pulse: software consumed one message.
- `i_rd_tag`  in  4  queue consumed.
- `i_intr_clear`  in  32  W1C level. Bit q clears status q; bits above NUM_Q-1 are ignored.
- `i_intr_enable`  in  32  interrupt mask. Bit q enables queue q.
- `i_wptr_sel`  in  4  queue selected for `o_q_wptr`.
- `o_intr_status`  out  32  {zero, status[NUM_Q-1:0]}.
- `o_q_wptr`  out  32  {20'h0, pend[sel][3:0], 2'b0, wptr[sel][5:0]}. Equals 0 if sel ≥ NUM_Q.
- `o_err_cnt`  out  32  {bad_tag[7:0], overflow[7:0], len_err[7:0], 8'h0}.
- `o_msg_interrupt`  out  1  level interrupt.

## Operation
- **Reset** (`rst_n`=0 at a `clk` edge): all wptr, pend, status, error counters and `o_msg_interrupt` go to 0. Every output reads 0 the cycle after reset. A reset mid-stream discards all state, and a pulse sampled in the same cycle as reset is ignored.
- **Completion handling** on `i_asm_valid`. Exactly one outcome applies, checked in priority order:
  1. `i_asm_tag` ≥ NUM_Q: bad_tag++. No queue state changes.
  2. `i_asm_len` == 0 or > QDEPTH: len_err++. No queue state changes.
  3. pend[tag] == MAX_PEND and no same-queue `i_rd_done` this cycle: overflow++. Message is dropped; wptr, pend and status are unchanged.
  4. Otherwise the message is accepted: wptr[tag] ← (wptr[tag] + len) mod QDEPTH, wrapping naturally in PTR_W bits. pend[tag] increments. status[tag] is set.
- **Consume** on `i_rd_done`: if `i_rd_tag` < NUM_Q and pend > 0, pend decrements. Otherwise the pulse is ignored and no counter is affected.
- **Accept and consume on the same queue in the same cycle**: pend is unchanged. This holds even at MAX_PEND, where the completion is accepted.
- **Accept and consume on different queues in the same cycle**: both updates apply independently.
- **Status set/clear**: a clear bit of 1 clears status while asserted. If set and clear hit the same bit in the same cycle, set wins.
- **Error counters**: 8-bit, saturate at 255, cleared only by reset.
- **Interrupt**: `o_msg_interrupt` ← |(status & enable[NUM_Q-1:0]), registered from the status register.

## Timing
- A completion at edge N updates wptr, pend, status and the error counters after edge N, so they are visible in cycle N+1.
- `o_msg_interrupt` reflects the status and enable of cycle N+1 at edge N+1, i.e. a 2-cycle latency from `i_asm_valid`.
- Clearing follows the same path: clear sampled at edge N → status bit low in N+1 → interrupt low in N+2.
- An enable change propagates to the interrupt in 1 cycle.
- `o_intr_status`, `o_err_cnt` and `o_q_wptr` are combinational views of registers. `o_q_wptr` follows `i_wptr_sel` in the same cycle.
- No back-pressure. A completion can be accepted every cycle, back-to-back, including on the same queue.

## Test plan
- **Accept and wrap:** reset; then completion tag 3 len 40 followed by tag 3 len 30 → wptr[3]=6 (70 mod 64), pend[3]=2, status=0x8. With enable=0x8, interrupt rises 2 cycles after the first pulse.
- **Error paths:** tag 15 len 4 → bad_tag=1. Tag 2 len 0 and tag 2 len 65 → len_err=2. Queue 2 state remains 0 throughout.
- **Overflow:** 15 completions to tag 0 → pend=15. A 16th → overflow=1, wptr unchanged. A 17th sent with a simultaneous `i_rd_done` tag 0 → accepted, pend=15.
- **Status clear:** status bit 5 set, then clear=0x20 for 1 cycle → status 0 next cycle, interrupt 0 the cycle after. Clear and set of bit 5 in the same cycle → bit stays 1.
- **Consume underflow:** `i_rd_done` tag 7 with pend[7]=0 → pend stays 0 and all counters are unchanged.
- **Reset mid-stream:** queues 1 and 4 have nonzero state and `rst_n` is asserted together with a completion → all outputs read 0 next cycle and the completion is lost. `o_q_wptr` with sel=14 reads 0.
